// File: rtl/fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_pkg - shared types and helpers for the dual-clock FIFO companions. Rev 1.0
// ---------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } rd_adapt_state_t;

  // Occupancy counters need one bit more than the pointers to represent "full".
  function automatic int lvl_width(input int depth);
    return (depth < 2) ? 2 : $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_sync_buf - single-clock register-array FIFO with push/pop/clear/level. Rev 1.0
// ---------------------------------------------------------------------------
module fifo_sync_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = lvl_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  // A push into a full buffer is still accepted when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push_ok && !clr_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream_adapter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_rd_stream_adapter - FIFO pop port to valid/ready stream with credit prefetch. Rev 1.0
// ---------------------------------------------------------------------------
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int BITWIDTH  = 32,
  parameter int BUF_DEPTH = 4,
  localparam int LVL_W    = lvl_width(BUF_DEPTH)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                FIFO_EMPTY,
  output logic                FIFO_R_EN,
  input  logic [BITWIDTH-1:0] FIFO_DATA,
  input  logic                FIFO_DATA_VALID,
  input  logic                FLUSH,
  output logic [BITWIDTH-1:0] M_DATA,
  output logic                M_VALID,
  input  logic                M_READY,
  output logic [LVL_W-1:0]    LEVEL,
  output logic                OVERFLOW_ERR
);

  rd_adapt_state_t state_q, state_d;
  logic            inflight_q, inflight_d;
  logic            ovf_q, ovf_d;
  logic            r_en_w;
  logic            head_pop_w;
  logic            push_w;
  logic            flush_w;
  logic            buf_empty_w;
  logic            buf_full_w;
  logic [LVL_W:0]  used_w;
  logic [LVL_W:0]  limit_w;

  assign M_VALID      = !buf_empty_w;
  assign head_pop_w   = M_VALID && M_READY;
  assign flush_w      = FLUSH && (state_q == RUN);
  assign push_w       = FIFO_DATA_VALID && (state_q == RUN) && !FLUSH;
  assign OVERFLOW_ERR = ovf_q;
  assign FIFO_R_EN    = r_en_w;

  // Credit check: buffered + in flight + this pop must fit after this cycle's head pop.
  assign used_w  = (LVL_W+1)'(LEVEL) + (LVL_W+1)'(inflight_q);
  assign limit_w = (LVL_W+1)'(BUF_DEPTH) + (LVL_W+1)'(head_pop_w);

  fifo_sync_buf #(
    .WIDTH (BITWIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (flush_w),
    .push_i  (push_w),
    .pop_i   (head_pop_w),
    .data_i  (FIFO_DATA),
    .data_o  (M_DATA),
    .level_o (LEVEL),
    .empty_o (buf_empty_w),
    .full_o  (buf_full_w)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= RUN;
      inflight_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    inflight_d = r_en_w && !FIFO_EMPTY;
    ovf_d      = ovf_q | (push_w && buf_full_w && !head_pop_w);
    case (state_q)
      RUN:  if (FLUSH && (inflight_q || r_en_w)) state_d = DROP;
      DROP: state_d = RUN;
    endcase
  end

  always_comb begin
    r_en_w = !RST && (state_q == RUN) && !FLUSH && !FIFO_EMPTY && (used_w < limit_w);
  end

`ifndef SYNTHESIS
  a_valid_tracks_inflight: assert property (
    @(posedge CLK) disable iff (RST) FIFO_DATA_VALID == inflight_q
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream_adapter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream_adapter - directed bench with a behavioural one-cycle-latency FIFO. Rev 1.0
// ---------------------------------------------------------------------------
module tb_fifo_rd_stream_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic        fifo_r_en;
  logic [31:0] fifo_data;
  logic        fifo_dvalid;
  logic        flush = 1'b0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [2:0]  level;
  logic        ovf;

  logic [31:0] tbmem [1024];
  logic [9:0]  wr_idx = '0;
  logic [9:0]  rd_idx = '0;

  logic [31:0] got   [512];
  int          got_k [512];
  int          got_n, ren_cnt, max_lvl;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          mism;

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(
    .BITWIDTH  (32),
    .BUF_DEPTH (4)
  ) dut (
    .CLK             (clk),
    .RST             (rst),
    .FIFO_EMPTY      (fifo_empty),
    .FIFO_R_EN       (fifo_r_en),
    .FIFO_DATA       (fifo_data),
    .FIFO_DATA_VALID (fifo_dvalid),
    .FLUSH           (flush),
    .M_DATA          (m_data),
    .M_VALID         (m_valid),
    .M_READY         (m_ready),
    .LEVEL           (level),
    .OVERFLOW_ERR    (ovf)
  );

  // Read-side FIFO model: data and valid appear the cycle after a pop.
  assign fifo_empty = (wr_idx == rd_idx);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_dvalid <= 1'b0;
      fifo_data   <= '0;
    end else begin
      fifo_dvalid <= fifo_r_en && !fifo_empty;
      if (fifo_r_en && !fifo_empty) begin
        fifo_data <= tbmem[rd_idx];
        rd_idx    <= rd_idx + 10'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    tbmem[wr_idx] = v;
    wr_idx = wr_idx + 10'd1;
  endtask

  task automatic clr();
    got_n   = 0;
    ren_cnt = 0;
    max_lvl = 0;
  endtask

  // Runs n cycles from posedge+1; samples at negedge, drives after the next posedge.
  task automatic run(input int n, input bit rnd);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (got_n < 512) begin
          got[got_n]   = m_data;
          got_k[got_n] = c;
        end
        got_n++;
      end
      if (fifo_r_en) ren_cnt++;
      if (int'(level) > max_lvl) max_lvl = int'(level);
      @(posedge clk);
      #1;
      if (rnd) m_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_r_en",  32'(fifo_r_en), 32'd0);
    check("rst_valid", 32'(m_valid),   32'd0);
    check("rst_data",  m_data,         32'd0);
    check("rst_level", 32'(level),     32'd0);
    check("rst_ovf",   32'(ovf),       32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Streaming at full rate
    m_ready = 1'b1;
    clr();
    for (int i = 0; i < 16; i++) push(32'(i));
    #1;
    check("stream_first_ren", 32'(fifo_r_en), 32'd1);
    check("stream_no_early_valid", 32'(m_valid), 32'd0);
    run(40, 1'b0);
    check("stream_beats", 32'(got_n), 32'd16);
    for (int i = 0; i < 16; i++) check("stream_data", got[i], 32'(i));
    check("stream_first_beat_cycle", 32'(got_k[0]), 32'd2);
    check("stream_last_beat_cycle", 32'(got_k[15]), 32'd17);
    check("stream_max_level", 32'(max_lvl), 32'd1);
    check("stream_pops", 32'(ren_cnt), 32'd16);

    // Back-pressure
    m_ready = 1'b0;
    clr();
    for (int i = 0; i < 10; i++) push(32'h100 + 32'(i));
    run(20, 1'b0);
    check("bp_pops", 32'(ren_cnt), 32'd4);
    check("bp_level", 32'(level), 32'd4);
    check("bp_r_en_stalled", 32'(fifo_r_en), 32'd0);
    m_ready = 1'b1;
    #1;
    check("bp_full_credit_pop", 32'(fifo_r_en), 32'd1);
    clr();
    run(30, 1'b0);
    check("bp_beats", 32'(got_n), 32'd10);
    for (int i = 0; i < 10; i++) check("bp_data", got[i], 32'h100 + 32'(i));
    check("bp_pops_rest", 32'(ren_cnt), 32'd6);
    check("bp_ovf", 32'(ovf), 32'd0);

    // Random ready toggling
    clr();
    for (int i = 0; i < 200; i++) push(32'h1000 + 32'(i));
    run(800, 1'b1);
    m_ready = 1'b1;
    run(10, 1'b0);
    check("tog_beats", 32'(got_n), 32'd200);
    mism = 0;
    for (int i = 0; i < 200; i++) if (got[i] !== 32'h1000 + 32'(i)) mism++;
    check("tog_order_mismatches", 32'(mism), 32'd0);
    check("tog_level_bound", 32'(max_lvl <= 4), 32'd1);
    check("tog_ovf", 32'(ovf), 32'd0);

    // Flush with a word in flight
    m_ready = 1'b0;
    clr();
    push(32'hA0); push(32'hA1); push(32'hA2); push(32'hAB); push(32'hC0); push(32'hC1);
    run(4, 1'b0);
    check("flush_pre_level", 32'(level), 32'd3);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    check("flush_valid", 32'(m_valid), 32'd0);
    check("flush_level", 32'(level), 32'd0);
    check("flush_drop_no_pop", 32'(fifo_r_en), 32'd0);
    m_ready = 1'b1;
    clr();
    run(12, 1'b0);
    check("flush_beats", 32'(got_n), 32'd2);
    check("flush_next_word", got[0], 32'hC0);
    check("flush_second_word", got[1], 32'hC1);

    // Single word after idle
    clr();
    run(20, 1'b0);
    check("idle_no_pops", 32'(ren_cnt), 32'd0);
    clr();
    push(32'h55);
    run(10, 1'b0);
    check("single_pops", 32'(ren_cnt), 32'd1);
    check("single_beats", 32'(got_n), 32'd1);
    check("single_data", got[0], 32'h55);
    check("single_valid_after", 32'(m_valid), 32'd0);

    // Reset mid-stream
    m_ready = 1'b0;
    clr();
    for (int i = 0; i < 5; i++) push(32'h200 + 32'(i));
    run(3, 1'b0);
    check("midrst_pre_level", 32'(level), 32'd2);
    rst = 1'b1;
    #1;
    check("midrst_r_en",  32'(fifo_r_en), 32'd0);
    check("midrst_valid", 32'(m_valid),   32'd0);
    check("midrst_data",  m_data,         32'd0);
    check("midrst_level", 32'(level),     32'd0);
    check("midrst_ovf",   32'(ovf),       32'd0);
    wr_idx = rd_idx;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    run(10, 1'b0);
    check("midrst_no_pops", 32'(ren_cnt), 32'd0);
    check("midrst_idle_valid", 32'(m_valid), 32'd0);
    check("midrst_idle_level", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
